// File: rtl/fsm_state_rle_if.sv
// Record output port of the state-stream run-length encoder.
// The encoder drives valid/state/len; the trace consumer drives ready.
interface fsm_state_rle_if #(
  parameter int SW = 3,
  parameter int CW = 8
);
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_state;
  logic [CW-1:0] out_len;

  modport master (output out_valid, output out_state, output out_len, input out_ready);
  modport slave  (input out_valid, input out_state, input out_len, output out_ready);
endinterface

// File: rtl/fsm_state_rle.sv
// Run-length encoder for an FSM state stream.
// Sampled state codes are folded into {state, run length} records. Records
// are queued in a small registered FIFO and drained over a valid/ready port.
// Out-of-range codes are flagged but still encoded. Records that arrive
// while the FIFO is full are dropped and counted.
module fsm_state_rle #(
  parameter int SW         = 3,
  parameter int NUM_STATES = 7,
  parameter int CW         = 8,
  parameter int DEPTH      = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic [SW-1:0] y,
  input  logic          flush,
  fsm_state_rle_if.master out_if,
  output logic          illegal,
  output logic [7:0]    drop_count,
  output logic          overflow
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LEN_MAX = '1;
  localparam logic [SW:0]   NS_L    = (SW+1)'(NUM_STATES);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [SW-1:0] state;
    logic [CW-1:0] len;
  } rec_t;

  // run tracker
  logic          open_q, open_d;
  logic [SW-1:0] cur_state_q, cur_state_d;
  logic [CW-1:0] cur_len_q, cur_len_d;
  // status
  logic          illegal_q, illegal_d;
  logic [7:0]    drop_count_q, drop_count_d;
  logic          overflow_q, overflow_d;
  // fifo
  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;

  logic push, pop, full, push_ok, drop;
  rec_t push_rec;

  // Run tracking: decide whether this cycle closes a run and what it holds.
  always_comb begin
    open_d      = open_q;
    cur_state_d = cur_state_q;
    cur_len_d   = cur_len_q;
    illegal_d   = illegal_q;
    push        = 1'b0;
    push_rec    = '{state: cur_state_q, len: cur_len_q};
    if (en) begin
      if ({1'b0, y} >= NS_L) illegal_d = 1'b1;
      if (!open_q) begin
        open_d      = 1'b1;
        cur_state_d = y;
        cur_len_d   = CW'(1);
      end else if (y != cur_state_q) begin
        push        = 1'b1;
        cur_state_d = y;
        cur_len_d   = CW'(1);
      end else if (cur_len_q == LEN_MAX) begin
        // Saturated run is emitted and a new run of the same state begins.
        push      = 1'b1;
        cur_len_d = CW'(1);
      end else begin
        cur_len_d = cur_len_q + CW'(1);
      end
    end else if (flush && open_q) begin
      push   = 1'b1;
      open_d = 1'b0;
    end
  end

  // FIFO bookkeeping: a pop frees a slot for a same-cycle push when full.
  always_comb begin
    mem_d        = mem_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    full         = (count_q == DEPTH_L);
    pop          = (count_q != '0) && out_if.out_ready;
    push_ok      = push && (!full || pop);
    drop         = push && full && !pop;
    if (push_ok) begin
      mem_d[wptr_q] = push_rec;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) rptr_d = rptr_q + AW'(1);
    if (push_ok && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push_ok) count_d = count_q - (AW+1)'(1);
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end
  end

  // State register; reset discards the open run and all queued records.
  always_ff @(posedge clock) begin
    if (reset) begin
      open_q       <= 1'b0;
      cur_state_q  <= '0;
      cur_len_q    <= '0;
      illegal_q    <= 1'b0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      open_q       <= open_d;
      cur_state_q  <= cur_state_d;
      cur_len_q    <= cur_len_d;
      illegal_q    <= illegal_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      mem_q        <= mem_d;
    end
  end

  // Head of the FIFO is presented straight from storage.
  always_comb begin
    out_if.out_valid = (count_q != '0);
    out_if.out_state = mem_q[rptr_q].state;
    out_if.out_len   = mem_q[rptr_q].len;
    illegal          = illegal_q;
    drop_count       = drop_count_q;
    overflow         = overflow_q;
  end

endmodule

// File: tb/tb_fsm_state_rle.sv
// Bench for fsm_state_rle: two instances (CW=8 and CW=4) share one stimulus
// stream; each is compared every cycle against a queue-based reference.
module tb_fsm_state_rle;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [2:0] y = '0;
  logic       flush = 1'b0;
  logic       ready = 1'b0;

  logic       ill8, ovf8, ill4, ovf4;
  logic [7:0] dc8, dc4;

  fsm_state_rle_if #(.SW(3), .CW(8)) if8 ();
  fsm_state_rle_if #(.SW(3), .CW(4)) if4 ();
  assign if8.out_ready = ready;
  assign if4.out_ready = ready;

  fsm_state_rle #(.SW(3), .NUM_STATES(7), .CW(8), .DEPTH(4)) u8 (
    .clock(clock), .reset(reset), .en(en), .y(y), .flush(flush),
    .out_if(if8), .illegal(ill8), .drop_count(dc8), .overflow(ovf8));

  fsm_state_rle #(.SW(3), .NUM_STATES(7), .CW(4), .DEPTH(4)) u4 (
    .clock(clock), .reset(reset), .en(en), .y(y), .flush(flush),
    .out_if(if4), .illegal(ill4), .drop_count(dc4), .overflow(ovf4));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // reference: index 0 -> CW=8, index 1 -> CW=4; records are state*65536+len
  int m_open[2], m_st[2], m_len[2], m_ill[2], m_drop[2], m_ovf[2];
  int q[2][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_open[i] = 0; m_st[i] = 0; m_len[i] = 0;
      m_ill[i] = 0; m_drop[i] = 0; m_ovf[i] = 0;
      q[i].delete();
    end
  endtask

  task automatic model_edge(input int i, input bit e, input int yy, input bit f, input bit r);
    int  mx;
    bit  push;
    bit  pop;
    int  rec;
    mx   = (i == 0) ? 255 : 15;
    push = 0;
    rec  = 0;
    pop  = (q[i].size() > 0) && r;
    if (e) begin
      if (yy >= 7) m_ill[i] = 1;
      if (m_open[i] == 0) begin
        m_open[i] = 1; m_st[i] = yy; m_len[i] = 1;
      end else if (yy != m_st[i] || m_len[i] == mx) begin
        push = 1; rec = m_st[i] * 65536 + m_len[i];
        m_st[i] = yy; m_len[i] = 1;
      end else begin
        m_len[i]++;
      end
    end else if (f && m_open[i] != 0) begin
      push = 1; rec = m_st[i] * 65536 + m_len[i];
      m_open[i] = 0;
    end
    if (pop) void'(q[i].pop_front());
    if (push) begin
      if (q[i].size() < 4) q[i].push_back(rec);
      else begin
        m_ovf[i] = 1;
        if (m_drop[i] < 255) m_drop[i]++;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic       v, il, ov;
      logic [2:0] s;
      logic [7:0] l, dc;
      if (i == 0) begin
        v = if8.out_valid; s = if8.out_state; l = if8.out_len;
        il = ill8; ov = ovf8; dc = dc8;
      end else begin
        v = if4.out_valid; s = if4.out_state; l = {4'b0, if4.out_len};
        il = ill4; ov = ovf4; dc = dc4;
      end
      chk($sformatf("out_valid[%0d]", i), 32'(v), 32'(q[i].size() > 0));
      if (q[i].size() > 0) begin
        chk($sformatf("out_state[%0d]", i), 32'(s), 32'(q[i][0] / 65536));
        chk($sformatf("out_len[%0d]", i), 32'(l), 32'(q[i][0] % 65536));
      end
      chk($sformatf("illegal[%0d]", i), 32'(il), 32'(m_ill[i]));
      chk($sformatf("overflow[%0d]", i), 32'(ov), 32'(m_ovf[i]));
      chk($sformatf("drop_count[%0d]", i), 32'(dc), 32'(m_drop[i]));
    end
  endtask

  task automatic step(input bit e, input int yy, input bit f, input bit r);
    en = e; y = 3'(yy); flush = f; ready = r;
    @(posedge clock);
    for (int i = 0; i < 2; i++) model_edge(i, e, yy, f, r);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; flush = 1'b0; ready = 1'b0;
    @(posedge clock);
    model_clear();
    #1;
    check_all();
    chk("rst_state8", 32'(if8.out_state), 32'd0);
    chk("rst_len8", 32'(if8.out_len), 32'd0);
    chk("rst_len4", 32'(if4.out_len), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    int seq[8];
    int ry;
    seq = '{0, 1, 2, 3, 4, 5, 6, 0};
    model_clear();
    #2;
    do_reset();
    do_reset();

    // one state per cycle, consumer always ready
    foreach (seq[k]) step(1, seq[k], 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);

    // run of five, terminated by a new state, then flushed
    repeat (5) step(1, 3, 0, 1);
    step(1, 4, 0, 1);
    chk("run5_len", 32'(if8.out_len), 32'd5);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // twenty samples: saturates the narrow counter at 15
    repeat (20) step(1, 2, 0, 1);
    step(1, 5, 0, 1);
    repeat (2) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    repeat (2) step(0, 0, 0, 1);

    // back-pressure: six runs close into a four-deep FIFO
    for (int v = 0; v < 7; v++) step(1, v, 0, 0);
    chk("ovf_drops", 32'(dc8), 32'd2);
    chk("ovf_flag", 32'(ovf8), 32'd1);
    repeat (2) step(0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 1);

    // full FIFO with a pop and a push on the same edge
    for (int v = 0; v < 4; v++) step(1, v, 0, 0);
    step(1, 4, 0, 1);
    chk("full_pp_drops", 32'(dc8), 32'd2);
    repeat (5) step(0, 0, 0, 1);

    // illegal code 7 is flagged and still encoded
    repeat (3) step(1, 7, 0, 1);
    step(1, 1, 0, 1);
    chk("illegal_set", 32'(ill8), 32'd1);
    step(0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1);
    chk("illegal_sticky", 32'(ill8), 32'd1);

    // reset with an open run of three and two queued records
    step(1, 2, 0, 0);
    step(1, 3, 0, 0);
    step(1, 4, 0, 0);
    step(1, 4, 0, 0);
    step(1, 4, 0, 0);
    do_reset();
    chk("rst_valid", 32'(if8.out_valid), 32'd0);
    step(1, 5, 0, 1);
    step(1, 6, 0, 1);
    chk("fresh_state", 32'(if8.out_state), 32'd5);
    chk("fresh_len", 32'(if8.out_len), 32'd1);
    step(0, 0, 1, 1);
    repeat (2) step(0, 0, 0, 1);

    // long run saturates the wide counter at 255
    repeat (300) step(1, 1, 0, 1);
    step(1, 2, 0, 1);
    step(0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1);

    // randomized traffic with sticky runs and occasional resets
    ry = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) > 7) ry = int'($urandom_range(0, 7));
      if ($urandom_range(0, 599) == 0) do_reset();
      else step($urandom_range(0, 9) < 8, ry, $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
